mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. Consumes the EX/MEM register outputs and performs data-RAM reads and writes plus memory-mapped peripheral access: a reload timer, an LED register, a 7-segment register and a free-running systick counter. It produces the load data that is passed into the MEM/WB register, along with the timer interrupt request.

---
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the five-stage pipeline: data RAM plus memory-mapped timer, LED,
// 7-segment and systick registers. Loads are combinational; stores commit on the edge.
module mem_stage #(
    parameter int RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [31:0] ALUOut_MEM,
    input  logic [31:0] rt_MEM,
    input  logic        LoadByte_MEM,
    output logic [31:0] MemData_MEM,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irq
);
    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] ADDR_DIGI    = 32'h4000_0010;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    // The RAM must clear on reset, so it is a register array rather than block RAM.
    logic [31:0]   ram_reg [RAM_WORDS];
    logic [31:0]   th_reg, th_next;
    logic [31:0]   tl_reg, tl_next;
    logic [2:0]    tcon_reg, tcon_next;
    logic [7:0]    led_reg, led_next;
    logic [11:0]   digi_reg, digi_next;
    logic [31:0]   systick_reg;

    logic          ram_hit;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;

    assign ram_hit  = ({1'b0, ALUOut_MEM} < RAM_BYTES);
    assign word_idx = ALUOut_MEM[AW+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
                ram_reg[i] <= '0;
            end
        end else if (MemWrite_MEM && ram_hit) begin
            ram_reg[word_idx] <= rt_MEM;
        end
    end

    // Timer update first, then CPU writes override it for the same register.
    always_comb begin
        th_next   = th_reg;
        tl_next   = tl_reg;
        tcon_next = tcon_reg;
        led_next  = led_reg;
        digi_next = digi_reg;
        if (tcon_reg[0]) begin
            if (tl_reg == 32'hFFFF_FFFF) begin
                tl_next = th_reg;
                if (tcon_reg[1]) begin
                    tcon_next[2] = 1'b1;
                end
            end else begin
                tl_next = tl_reg + 32'd1;
            end
        end
        if (MemWrite_MEM) begin
            case (ALUOut_MEM)
                ADDR_TH:   th_next   = rt_MEM;
                ADDR_TL:   tl_next   = rt_MEM;
                ADDR_TCON: tcon_next = rt_MEM[2:0];
                ADDR_LED:  led_next  = rt_MEM[7:0];
                ADDR_DIGI: digi_next = rt_MEM[11:0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_reg      <= '0;
            tl_reg      <= '0;
            tcon_reg    <= '0;
            led_reg     <= '0;
            digi_reg    <= '0;
            systick_reg <= '0;
        end else begin
            th_reg      <= th_next;
            tl_reg      <= tl_next;
            tcon_reg    <= tcon_next;
            led_reg     <= led_next;
            digi_reg    <= digi_next;
            systick_reg <= systick_reg + 32'd1;
        end
    end

    always_comb begin
        rd_word = '0;
        if (ram_hit) begin
            rd_word = ram_reg[word_idx];
        end else begin
            case (ALUOut_MEM)
                ADDR_TH:      rd_word = th_reg;
                ADDR_TL:      rd_word = tl_reg;
                ADDR_TCON:    rd_word = {29'd0, tcon_reg};
                ADDR_LED:     rd_word = {24'd0, led_reg};
                ADDR_DIGI:    rd_word = {20'd0, digi_reg};
                ADDR_SYSTICK: rd_word = systick_reg;
                default:      rd_word = '0;
            endcase
        end
        case (ALUOut_MEM[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        MemData_MEM = '0;
        if (MemRead_MEM) begin
            MemData_MEM = LoadByte_MEM ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
        end
    end

    assign led  = led_reg;
    assign digi = digi_reg;
    assign irq  = tcon_reg[2];
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a behavioural model of the memory map tracks every edge and a
// negedge process compares all outputs against it; directed steps add literal checks.
module tb_mem_stage;
    localparam logic [31:0] TH      = 32'h4000_0000;
    localparam logic [31:0] TL      = 32'h4000_0004;
    localparam logic [31:0] TCON    = 32'h4000_0008;
    localparam logic [31:0] LED     = 32'h4000_000C;
    localparam logic [31:0] DIGI    = 32'h4000_0010;
    localparam logic [31:0] SYSTICK = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_MEM, MemWrite_MEM, LoadByte_MEM;
    logic [31:0] ALUOut_MEM, rt_MEM;
    logic [31:0] MemData_MEM;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;

    always #5 clk = ~clk;

    mem_stage #(.RAM_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .ALUOut_MEM(ALUOut_MEM), .rt_MEM(rt_MEM), .LoadByte_MEM(LoadByte_MEM),
        .MemData_MEM(MemData_MEM), .led(led), .digi(digi), .irq(irq)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model of the visible state.
    logic [31:0] m_ram [256];
    logic [31:0] m_th, m_tl, m_systick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 256; i++) m_ram[i] = '0;
        m_th = '0; m_tl = '0; m_tcon = '0; m_led = '0; m_digi = '0; m_systick = '0;
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] a);
        if (a < 32'd1024) return m_ram[a[9:2]];
        case (a)
            TH:      return m_th;
            TL:      return m_tl;
            TCON:    return {29'd0, m_tcon};
            LED:     return {24'd0, m_led};
            DIGI:    return {20'd0, m_digi};
            SYSTICK: return m_systick;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic rd, input logic lb, input logic [31:0] a);
        logic [31:0] w;
        if (!rd) return 32'd0;
        w = m_word(a);
        if (!lb) return w;
        w = w >> (8 * int'(a[1:0]));
        return {{24{w[7]}}, w[7:0]};
    endfunction

    // One clock edge applied to the model using the inputs held across it.
    task automatic m_edge();
        logic [31:0] ntl;
        logic [2:0]  ntc;
        ntl = m_tl;
        ntc = m_tcon;
        if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                ntl = m_th;
                if (m_tcon[1]) ntc[2] = 1'b1;
            end else begin
                ntl = m_tl + 32'd1;
            end
        end
        if (MemWrite_MEM) begin
            if (ALUOut_MEM < 32'd1024) m_ram[ALUOut_MEM[9:2]] = rt_MEM;
            else begin
                case (ALUOut_MEM)
                    TH:      m_th = rt_MEM;
                    TL:      ntl = rt_MEM;
                    TCON:    ntc = rt_MEM[2:0];
                    LED:     m_led = rt_MEM[7:0];
                    DIGI:    m_digi = rt_MEM[11:0];
                    default: ;
                endcase
            end
        end
        m_tl = ntl;
        m_tcon = ntc;
        m_systick = m_systick + 32'd1;
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("rdata", MemData_MEM, m_load(MemRead_MEM, LoadByte_MEM, ALUOut_MEM));
            chk("led", {24'd0, led}, {24'd0, m_led});
            chk("digi", {20'd0, digi}, {20'd0, m_digi});
            chk("irq", {31'd0, irq}, {31'd0, m_tcon[2]});
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic lb);
        MemRead_MEM = rd; MemWrite_MEM = wr; ALUOut_MEM = a; rt_MEM = d; LoadByte_MEM = lb;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d, 1'b0);
        tick();
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic lb,
                          input logic [31:0] exp);
        drive(1'b1, 1'b0, a, 32'd0, lb);
        #1;
        chk(name, MemData_MEM, exp);
        tick();
    endtask

    logic [31:0] s0, s1, s2, s3, ra, rd_data;
    int          k;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        m_reset();
        #1;
        chk("reset_led", {24'd0, led}, 32'd0);
        chk("reset_digi", {20'd0, digi}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_rdata", MemData_MEM, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cmp_en = 1'b1;

        // RAM word and byte loads
        wr_cyc(32'h10, 32'h1234_5678);
        rd_chk("lw_0x10", 32'h10, 1'b0, 32'h1234_5678);
        rd_chk("lb_0x13", 32'h13, 1'b1, 32'h0000_0012);
        wr_cyc(32'h10, 32'h0000_00F0);
        rd_chk("lb_0x10_sext", 32'h10, 1'b1, 32'hFFFF_FFF0);

        // Timer reload and interrupt
        wr_cyc(TH, 32'hFFFF_FFFE);
        wr_cyc(TL, 32'hFFFF_FFFE);
        wr_cyc(TCON, 32'd3);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        rd_chk("tl_after_edge1", TL, 1'b0, 32'hFFFF_FFFF);
        chk("irq_after_overflow", {31'd0, irq}, 32'd1);
        chk("model_irq_after_overflow", {29'd0, m_tcon}, 32'd7);
        rd_chk("tl_reloaded", TL, 1'b0, 32'hFFFF_FFFE);
        wr_cyc(TCON, 32'd3);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        chk("model_tcon_written", {29'd0, m_tcon}, 32'd3);
        wr_cyc(TCON, 32'd0);

        // LED / DIGI truncation and unmapped access
        wr_cyc(LED, 32'h0000_01A5);
        chk("led_trunc", {24'd0, led}, 32'h0000_00A5);
        wr_cyc(DIGI, 32'hFFFF_F123);
        chk("digi_trunc", {20'd0, digi}, 32'h0000_0123);
        wr_cyc(32'h4000_0018, 32'hFFFF_FFFF);
        chk("led_unmapped_wr", {24'd0, led}, 32'h0000_00A5);
        chk("digi_unmapped_wr", {20'd0, digi}, 32'h0000_0123);
        rd_chk("unmapped_rd", 32'h4000_0018, 1'b0, 32'd0);

        // SYSTICK
        drive(1'b1, 1'b0, SYSTICK, 32'd0, 1'b0);
        #1 s0 = MemData_MEM;
        tick();
        repeat (9) tick();
        #1 s1 = MemData_MEM;
        chk("systick_delta10", s1 - s0, 32'd10);
        tick();
        drive(1'b1, 1'b0, SYSTICK, 32'd0, 1'b0);
        #1 s2 = MemData_MEM;
        tick();
        wr_cyc(SYSTICK, 32'd0);
        drive(1'b1, 1'b0, SYSTICK, 32'd0, 1'b0);
        #1 s3 = MemData_MEM;
        chk("systick_wr_ignored", s3 - s2, 32'd2);
        tick();

        // TCON write on the overflow edge
        wr_cyc(TH, 32'h0000_0055);
        wr_cyc(TL, 32'hFFFF_FFFF);
        wr_cyc(TCON, 32'd3);
        wr_cyc(TCON, 32'd1);
        chk("coll_irq", {31'd0, irq}, 32'd0);
        chk("model_coll_tl", m_tl, 32'h0000_0055);
        rd_chk("coll_tl", TL, 1'b0, 32'h0000_0055);
        rd_chk("coll_tcon", TCON, 1'b0, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            k = int'($urandom_range(0, 9));
            rd_data = $urandom;
            case (k)
                0, 1, 2, 3: ra = 32'($urandom_range(0, 1023));
                4: begin
                    ra = TH;
                    if ($urandom_range(0, 1) == 0) rd_data = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
                end
                5: begin
                    ra = TL;
                    if ($urandom_range(0, 1) == 0) rd_data = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                end
                6: begin
                    ra = TCON;
                    if ($urandom_range(0, 3) != 0) rd_data[0] = 1'b1;
                end
                7: ra = ($urandom_range(0, 1) == 0) ? LED : DIGI;
                8: ra = SYSTICK;
                default: begin
                    case ($urandom_range(0, 3))
                        0: ra = 32'h4000_0018;
                        1: ra = 32'h4000_0001;
                        2: ra = 32'h0000_0400;
                        default: ra = 32'hC000_0008;
                    endcase
                end
            endcase
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ra, rd_data,
                  1'($urandom_range(0, 1)));
            tick();
        end

        // Asynchronous reset mid-count with nonzero outputs
        wr_cyc(TCON, 32'd0);
        wr_cyc(LED, 32'h0000_005A);
        wr_cyc(DIGI, 32'h0000_0321);
        wr_cyc(32'h10, 32'hCAFE_BABE);
        wr_cyc(TH, 32'd0);
        wr_cyc(TL, 32'hFFFF_FFFF);
        wr_cyc(TCON, 32'd3);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("pre_reset_irq", {31'd0, irq}, 32'd1);
        chk("pre_reset_led", {24'd0, led}, 32'h0000_005A);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_led", {24'd0, led}, 32'd0);
        chk("async_reset_digi", {20'd0, digi}, 32'd0);
        chk("async_reset_irq", {31'd0, irq}, 32'd0);
        chk("async_reset_rdata", MemData_MEM, 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_chk("ram4_after_reset", 32'h10, 1'b0, 32'd0);
        rd_chk("tl_after_reset", TL, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
